// File: rtl/pkt_rr_arbiter_pkg.sv
// Shared types and the round-robin search helper
// for the packet-aware stream arbiter.
package pkt_arb_pkg;

  typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_t;

  localparam int MAX_IN = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First requester after `last`, wrapping modulo n (n need not be 2^k)
  function automatic rr_pick_t rr_pick(
    input logic [MAX_IN-1:0] req,
    input logic [3:0]        last,
    input int                n
  );
    rr_pick_t   r;
    logic [4:0] cand;
    r = '0;
    for (int i = MAX_IN; i >= 1; i--) begin
      cand = {1'b0, last} + 5'(i);
      if (cand >= 5'(n)) cand = cand - 5'(n);
      if (i <= n && req[cand[3:0]]) begin
        r.found = 1'b1;
        r.idx   = cand[3:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pkt_rr_arbiter_st_pipe_reg.sv
// Single-entry valid/ready register slice; accepts a new
// beat whenever it is empty or its beat drains this cycle.
module st_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = in_ready ? in_valid : valid_q;
    data_d   = (in_ready && in_valid) ? in_data : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-aware round-robin arbiter: grant is held sop..eop
// so packets from different sources never interleave.
module pkt_rr_arbiter
  import pkt_arb_pkg::*;
#(
  parameter  int NUM_IN           = 4,
  parameter  int SYMBOL_PER_BEATS = 1,
  parameter  int BITS_PER_SYMBOL  = 20,
  parameter  int EMPTY_W          = 1,
  localparam int DATA_W = SYMBOL_PER_BEATS * BITS_PER_SYMBOL,
  localparam int SRC_W  = $clog2(NUM_IN)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN-1:0]         in_sop,
  input  logic [NUM_IN-1:0]         in_eop,
  input  logic [NUM_IN*EMPTY_W-1:0] in_empty,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [EMPTY_W-1:0]        out_empty,
  output logic [SRC_W-1:0]          out_src,
  output logic                      err_nosop
);

  localparam int PAY_W = DATA_W + EMPTY_W + 2 + SRC_W;

  arb_state_t       state_q, state_d;
  logic [SRC_W-1:0] last_q, last_d;
  logic [SRC_W-1:0] lock_q, lock_d;
  logic             err_q, err_d;
  logic             run_q;

  rr_pick_t         pick;
  logic [SRC_W-1:0] grant;
  logic             load_en, rdy_ok, acc;
  logic             sel_sop, sel_eop;
  logic [PAY_W-1:0] pay_d, pay_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= SRC_W'(NUM_IN - 1);
      lock_q  <= '0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      run_q   <= 1'b1;
    end
  end

  // Grant selection, ready generation and input mux
  always_comb begin
    pick    = rr_pick(MAX_IN'(in_valid), 4'(last_q), NUM_IN);
    grant   = (state_q == ST_LOCKED) ? lock_q
                                     : pick.idx[SRC_W-1:0];
    rdy_ok  = run_q && load_en &&
              (state_q == ST_LOCKED || pick.found);
    in_ready = rdy_ok ? (NUM_IN'(1) << grant) : '0;
    acc      = rdy_ok && in_valid[grant];
    sel_sop  = in_sop[grant];
    sel_eop  = in_eop[grant];
    pay_d = {
      sel_sop,
      sel_eop,
      in_empty[EMPTY_W*int'(grant) +: EMPTY_W],
      grant,
      in_data[DATA_W*int'(grant) +: DATA_W]
    };
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    lock_d  = lock_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          err_d = !sel_sop;
          if (sel_eop) begin
            last_d = grant;
          end else begin
            state_d = ST_LOCKED;
            lock_d  = grant;
          end
        end
      end
      ST_LOCKED: begin
        if (acc && sel_eop) begin
          state_d = ST_IDLE;
          last_d  = lock_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  st_pipe_reg #(.W(PAY_W)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (acc),
    .in_ready  (load_en),
    .in_data   (pay_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_q)
  );

  assign {out_sop, out_eop, out_empty, out_src, out_data} = pay_q;
  assign err_nosop = err_q;

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter: reset, fairness,
// packet lock, back-pressure scoreboard, error and reset.
module tb_pkt_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 20;
  localparam int EW = 1;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_sop;
  logic [N-1:0]    in_eop;
  logic [N*EW-1:0] in_empty;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_sop;
  logic            out_eop;
  logic [EW-1:0]   out_empty;
  logic [SW-1:0]   out_src;
  logic            err_nosop;

  int checks = 0;
  int errors = 0;

  pkt_rr_arbiter #(
    .NUM_IN(N), .SYMBOL_PER_BEATS(1),
    .BITS_PER_SYMBOL(20), .EMPTY_W(EW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sop(in_sop),
    .in_eop(in_eop), .in_empty(in_empty),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sop(out_sop),
    .out_eop(out_eop), .out_empty(out_empty),
    .out_src(out_src), .err_nosop(err_nosop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] dat(input int i,
                                        input int k);
    return {4'(i), 16'(k)};
  endfunction

  task automatic set_in(input int i, input logic v,
                        input logic s, input logic e,
                        input int k, input logic em);
    in_valid[i]        = v;
    in_sop[i]          = s;
    in_eop[i]          = e;
    in_empty[i]        = em;
    in_data[i*DW +: DW] = dat(i, k);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = '0;
    in_sop   = '0;
    in_eop   = '0;
    in_empty = '0;
    in_data  = '0;
    out_ready = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  logic [23:0] q[$];
  logic [23:0] exp_b;
  logic [15:0] rp;
  logic [24:0] snap;
  logic        prev_stall;
  int k0, k2, pop0, pop2, open_src, ex;

  initial begin
    // 1: reset with every requester valid
    rst_n    = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++)
      set_in(i, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    repeat (3) cyc();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_src", 32'(out_src), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_sop_eop", 32'({out_sop, out_eop}), 0);
    chk("rst_empty", 32'(out_empty), 0);
    chk("rst_err", 32'(err_nosop), 0);
    rst_n = 1'b1;
    cyc();
    chk("rel_in_ready", 32'(in_ready), 32'h1);
    chk("rel_out_valid", 32'(out_valid), 0);
    cyc();
    chk("first_valid", 32'(out_valid), 1);
    chk("first_src", 32'(out_src), 0);
    chk("first_data", 32'(out_data), 32'(dat(0, 0)));

    // 2: fairness with all inputs sending 1-beat packets
    ex = 1;
    for (int n = 0; n < 100; n++) begin
      cyc();
      chk("rr_valid", 32'(out_valid), 1);
      chk("rr_src", 32'(out_src), 32'(ex % 4));
      chk("rr_data", 32'(out_data), 32'(dat(ex % 4, 0)));
      ex++;
    end

    // 3: in0 5-beat packet locks out in1
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_in(0, 1'b1, k == 0, k == 4, k, 1'b0);
      set_in(1, 1'b1, 1'b1, 1'b1, 9, 1'b0);
      #1;
      chk("lock_in_ready", 32'(in_ready), 32'h1);
      if (k > 0) begin
        chk("lock_src", 32'(out_src), 0);
        chk("lock_data", 32'(out_data), 32'(dat(0, k - 1)));
        chk("lock_sop", 32'(out_sop), 32'(k == 1));
      end
      cyc();
    end
    chk("lock_last_eop", 32'(out_eop), 1);
    chk("lock_last_data", 32'(out_data), 32'(dat(0, 4)));
    set_in(0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    #1;
    chk("unlock_in_ready", 32'(in_ready), 32'h2);
    cyc();
    chk("unlock_src", 32'(out_src), 1);
    chk("unlock_data", 32'(out_data), 32'(dat(1, 9)));
    chk("unlock_sop", 32'(out_sop), 1);

    // 4: back-pressure with a fixed ready pattern
    do_reset();
    rp = 16'b1011_0010_1101_0110;
    k0 = 0; k2 = 0; pop0 = 0; pop2 = 0;
    open_src = -1;
    prev_stall = 1'b0;
    snap = '0;
    for (int c = 0; c < 70; c++) begin
      if (prev_stall)
        chk("bp_stable", 32'({out_valid, out_src, out_sop,
                              out_eop, out_data}), 32'(snap));
      if (c < 60) begin
        set_in(0, 1'b1, k0 % 3 == 0, k0 % 3 == 2, k0, 1'b0);
        set_in(2, 1'b1, k2 % 2 == 0, k2 % 2 == 1, k2, 1'b0);
        out_ready = rp[c % 16];
      end else begin
        in_valid = '0;
        out_ready = 1'b1;
      end
      #1;
      chk("bp_onehot", 32'($onehot0(in_ready)), 1);
      if (in_valid[0] && in_ready[0]) begin
        q.push_back({2'd0, in_sop[0], in_eop[0], dat(0, k0)});
        k0++;
      end
      if (in_valid[2] && in_ready[2]) begin
        q.push_back({2'd2, in_sop[2], in_eop[2], dat(2, k2)});
        k2++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("bp_underflow", 32'(q.size()), 1);
        end else begin
          exp_b = q.pop_front();
          chk("bp_beat", 32'({out_src, out_sop, out_eop,
                              out_data}), 32'(exp_b));
          if (open_src >= 0)
            chk("bp_nointerleave", 32'(out_src), 32'(open_src));
          open_src = out_eop ? -1 : int'(out_src);
          if (out_src == 2'd0) pop0++;
          if (out_src == 2'd2) pop2++;
        end
      end
      prev_stall = out_valid && !out_ready;
      snap = {out_valid, out_src, out_sop, out_eop, out_data};
      cyc();
    end
    chk("bp_drained", 32'(q.size()), 0);
    chk("bp_count0", 32'(pop0), 32'(k0));
    chk("bp_count2", 32'(pop2), 32'(k2));
    chk("bp_progress", 32'(k0 >= 10 && k2 >= 10), 1);

    // 5: beat without sop, then reset mid-packet
    do_reset();
    set_in(2, 1'b1, 1'b0, 1'b1, 7, 1'b1);
    #1;
    chk("nosop_in_ready", 32'(in_ready), 32'h4);
    cyc();
    set_in(2, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("nosop_valid", 32'(out_valid), 1);
    chk("nosop_src", 32'(out_src), 2);
    chk("nosop_sop", 32'(out_sop), 0);
    chk("nosop_empty", 32'(out_empty), 1);
    chk("nosop_data", 32'(out_data), 32'(dat(2, 7)));
    chk("nosop_err", 32'(err_nosop), 1);
    cyc();
    chk("nosop_err_clr", 32'(err_nosop), 0);
    chk("nosop_drained", 32'(out_valid), 0);
    for (int k = 0; k < 3; k++) begin
      set_in(1, 1'b1, k == 0, 1'b0, k, 1'b0);
      cyc();
    end
    chk("mid_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_ready", 32'(in_ready), 0);
    cyc();
    rst_n = 1'b1;
    set_in(1, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    set_in(3, 1'b1, 1'b1, 1'b1, 5, 1'b0);
    cyc();
    chk("post_rst_idle", 32'(in_ready), 32'h8);
    cyc();
    chk("post_rst_src", 32'(out_src), 3);
    chk("post_rst_data", 32'(out_data), 32'(dat(3, 5)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
